tuner_pwr_detect_phy: RTL and testbench

// - Producer side of tuner_pwr_detect_if: turns raw ADC power samples into windowed-average power updates for the consumer PHY.
// - The consumer (lock/search PHY) requests measurement with active and clears history with refresh.
// - Each update pulse tells the consumer to step its ring tune code. A settle gap after each update lets the heater/DAC settle before the next window.

---
 rtl/tuner_pwr_detect_phy_if.sv | 30 +++
 rtl/tuner_pwr_detect_phy.sv | 142 ++++++++++++++
 tb/tb_tuner_pwr_detect_phy.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/tuner_pwr_detect_phy_if.sv
// Handshake between the power-detect producer and the lock/search consumer PHY.
// The consumer drives active/refresh; the producer returns windowed power updates.
interface tuner_pwr_detect_if #(
    parameter int ADC_WIDTH = 8
);
    logic                 pwr_detect_active;
    logic                 pwr_detect_refresh;
    logic                 pwr_detect_update;
    logic [ADC_WIDTH-1:0] pwr_detect_pwr;
    logic [ADC_WIDTH-1:0] pwr_detect_pwr_prev;
    logic                 pwr_detect_slope_up;

    modport producer (
        input  pwr_detect_active,
        input  pwr_detect_refresh,
        output pwr_detect_update,
        output pwr_detect_pwr,
        output pwr_detect_pwr_prev,
        output pwr_detect_slope_up
    );

    modport consumer (
        output pwr_detect_active,
        output pwr_detect_refresh,
        input  pwr_detect_update,
        input  pwr_detect_pwr,
        input  pwr_detect_pwr_prev,
        input  pwr_detect_slope_up
    );
endinterface

// File: rtl/tuner_pwr_detect_phy.sv
// Averages 2^n valid ADC power samples per window, after an optional settle gap,
// and pulses update with the new average, the previous one and the slope direction.
module tuner_pwr_detect_phy #(
    parameter int ADC_WIDTH    = 8,
    parameter int AVG_LOG2_MAX = 4,
    parameter int SETTLE_WIDTH = 8
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [3:0]              i_cfg_avg_log2,
    input  logic [SETTLE_WIDTH-1:0] i_cfg_settle_cycles,
    input  logic [ADC_WIDTH-1:0]    i_adc_pwr,
    input  logic                    i_adc_val,
    tuner_pwr_detect_if.producer    pwr_detect_if
);
    localparam int ACC_W = ADC_WIDTH + AVG_LOG2_MAX;
    localparam int CNT_W = AVG_LOG2_MAX + 1;
    localparam int N_W   = $clog2(AVG_LOG2_MAX + 1);

    typedef enum logic [1:0] {PD_IDLE, PD_SETTLE, PD_ACCUM, PD_UPDATE} pd_state_t;

    pd_state_t               r_state;
    pd_state_t               w_state_next;
    logic [ACC_W-1:0]        r_acc;
    logic [CNT_W-1:0]        r_cnt;
    logic [SETTLE_WIDTH-1:0] r_settle_cnt;
    logic [N_W-1:0]          r_n;
    logic [ADC_WIDTH-1:0]    r_pwr;
    logic [ADC_WIDTH-1:0]    r_pwr_prev;
    logic                    r_slope_up;
    logic                    w_update;

    logic                    w_active;
    logic                    w_refresh;
    logic                    w_settle_zero;
    logic [N_W-1:0]          w_n_clamped;
    logic [ACC_W-1:0]        w_acc_sum;
    logic [CNT_W-1:0]        w_cnt_inc;
    logic                    w_last;
    logic [ADC_WIDTH-1:0]    w_pwr_new;

    assign w_active      = pwr_detect_if.pwr_detect_active;
    assign w_refresh     = pwr_detect_if.pwr_detect_refresh;
    assign w_settle_zero = (i_cfg_settle_cycles == '0);
    assign w_n_clamped   = (i_cfg_avg_log2 > 4'(AVG_LOG2_MAX)) ? N_W'(AVG_LOG2_MAX)
                                                               : N_W'(i_cfg_avg_log2);
    assign w_acc_sum     = r_acc + ACC_W'(i_adc_pwr);
    assign w_cnt_inc     = r_cnt + CNT_W'(1);
    assign w_last        = i_adc_val && (w_cnt_inc == (CNT_W'(1) << r_n));
    assign w_pwr_new     = ADC_WIDTH'(w_acc_sum >> r_n);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= PD_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Refresh outranks everything; dropping active abandons any window in flight.
    always_comb begin
        w_state_next = r_state;
        if (w_refresh) begin
            w_state_next = PD_IDLE;
        end else begin
            case (r_state)
                PD_IDLE: begin
                    if (w_active) begin
                        w_state_next = w_settle_zero ? PD_ACCUM : PD_SETTLE;
                    end
                end
                PD_SETTLE: begin
                    if (!w_active) begin
                        w_state_next = PD_IDLE;
                    end else if (r_settle_cnt <= SETTLE_WIDTH'(1)) begin
                        w_state_next = PD_ACCUM;
                    end
                end
                PD_ACCUM: begin
                    if (!w_active) begin
                        w_state_next = PD_IDLE;
                    end else if (w_last) begin
                        w_state_next = PD_UPDATE;
                    end
                end
                default: begin
                    if (w_active) begin
                        w_state_next = w_settle_zero ? PD_ACCUM : PD_SETTLE;
                    end else begin
                        w_state_next = PD_IDLE;
                    end
                end
            endcase
        end
    end

    always_comb begin
        w_update = (r_state == PD_UPDATE);
    end

    // Result registers load on the edge that accepts the last sample, so they are
    // already valid during the update pulse.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n || w_refresh) begin
            r_acc        <= '0;
            r_cnt        <= '0;
            r_settle_cnt <= '0;
            r_n          <= '0;
            r_pwr        <= '0;
            r_pwr_prev   <= '0;
            r_slope_up   <= 1'b0;
        end else begin
            if (w_state_next == PD_SETTLE && r_state != PD_SETTLE) begin
                r_settle_cnt <= i_cfg_settle_cycles;
            end else if (r_state == PD_SETTLE) begin
                r_settle_cnt <= r_settle_cnt - SETTLE_WIDTH'(1);
            end
            if (w_state_next == PD_ACCUM && r_state != PD_ACCUM) begin
                r_n <= w_n_clamped;
            end
            if (r_state == PD_ACCUM && w_state_next == PD_ACCUM) begin
                if (i_adc_val) begin
                    r_acc <= w_acc_sum;
                    r_cnt <= w_cnt_inc;
                end
            end else begin
                r_acc <= '0;
                r_cnt <= '0;
            end
            if (r_state == PD_ACCUM && w_state_next == PD_UPDATE) begin
                r_pwr      <= w_pwr_new;
                r_pwr_prev <= r_pwr;
                r_slope_up <= (w_pwr_new > r_pwr);
            end
        end
    end

    assign pwr_detect_if.pwr_detect_update   = w_update;
    assign pwr_detect_if.pwr_detect_pwr      = r_pwr;
    assign pwr_detect_if.pwr_detect_pwr_prev = r_pwr_prev;
    assign pwr_detect_if.pwr_detect_slope_up = r_slope_up;
endmodule

// File: tb/tb_tuner_pwr_detect_phy.sv
// Directed bench for tuner_pwr_detect_phy: a sample-queue model predicts outputs every
// cycle, and literal expectations pin the key scenarios.
module tb_tuner_pwr_detect_phy;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] cfg_n;
    logic [7:0] cfg_settle;
    logic [7:0] adc;
    logic       val;

    int n_tests = 0;
    int n_fail  = 0;

    tuner_pwr_detect_if #(.ADC_WIDTH(8)) u_if ();

    tuner_pwr_detect_phy #(
        .ADC_WIDTH(8), .AVG_LOG2_MAX(4), .SETTLE_WIDTH(8)
    ) dut (
        .i_clk              (clk),
        .i_rst_n            (rst_n),
        .i_cfg_avg_log2     (cfg_n),
        .i_cfg_settle_cycles(cfg_settle),
        .i_adc_pwr          (adc),
        .i_adc_val          (val),
        .pwr_detect_if      (u_if)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a window is a list of accepted samples; its average is sum >> n.
    bit     m_started = 0;
    bit     m_busy = 0;
    int     m_settle_left = 0;
    int     m_n = 0;
    int     q[$];
    bit     m_upd = 0;
    int     m_pwr = 0, m_prev = 0;
    bit     m_slope = 0;

    function automatic int clamp_n(input int v);
        return (v > 4) ? 4 : v;
    endfunction

    task automatic begin_window();
        m_busy = 1;
        m_settle_left = int'(cfg_settle);
        if (m_settle_left == 0) m_n = clamp_n(int'(cfg_n));
    endtask

    always @(posedge clk) begin
        int sum;
        int avg;
        m_started = 1;
        if (!rst_n || u_if.pwr_detect_refresh) begin
            m_busy = 0; m_settle_left = 0; q.delete(); m_upd = 0;
            m_pwr = 0; m_prev = 0; m_slope = 0;
        end else if (m_upd) begin
            m_upd = 0;
            q.delete();
            if (u_if.pwr_detect_active) begin_window(); else m_busy = 0;
        end else if (!m_busy) begin
            if (u_if.pwr_detect_active) begin_window();
        end else if (!u_if.pwr_detect_active) begin
            m_busy = 0;
            q.delete();
        end else if (m_settle_left > 0) begin
            m_settle_left--;
            if (m_settle_left == 0) m_n = clamp_n(int'(cfg_n));
        end else if (val) begin
            q.push_back(int'(adc));
            if (q.size() == (1 << m_n)) begin
                sum = 0;
                foreach (q[i]) sum += q[i];
                avg = sum >> m_n;
                m_prev = m_pwr;
                m_slope = (avg > m_pwr);
                m_pwr = avg;
                m_upd = 1;
                q.delete();
            end
        end
    end

    logic upd_last = 1'b0;
    always @(negedge clk) begin
        if (m_started) begin
            chk("model_update", u_if.pwr_detect_update, m_upd);
            chk("model_pwr", u_if.pwr_detect_pwr, m_pwr);
            chk("model_pwr_prev", u_if.pwr_detect_pwr_prev, m_prev);
            chk("model_slope_up", u_if.pwr_detect_slope_up, m_slope);
            chk("no_back_to_back_update", upd_last && u_if.pwr_detect_update, 0);
            if (u_if.pwr_detect_update)
                $display("[TB] update pwr=%0d prev=%0d slope_up=%0d at %0t",
                         u_if.pwr_detect_pwr, u_if.pwr_detect_pwr_prev,
                         u_if.pwr_detect_slope_up, $time);
            upd_last = u_if.pwr_detect_update;
        end
    end

    task automatic cyc(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic feed(input int v, input int k);
        for (int i = 0; i < k; i++) begin
            adc = 8'(v);
            val = 1'b1;
            cyc(1);
        end
        val = 1'b0;
    endtask

    task automatic wait_upd(input string name, input int budget);
        for (int i = 0; i < budget && !u_if.pwr_detect_update; i++) cyc(1);
        if (!u_if.pwr_detect_update) begin
            n_tests++;
            n_fail++;
            $display("[TB] FAIL %s: got no update, expected one within %0d cycles", name, budget);
        end
    endtask

    task automatic refresh_pulse();
        u_if.pwr_detect_refresh = 1'b1;
        cyc(1);
        u_if.pwr_detect_refresh = 1'b0;
    endtask

    initial begin
        int period;
        rst_n = 1'b0; cfg_n = 4'd2; cfg_settle = 8'd0; adc = 8'd0; val = 1'b0;
        u_if.pwr_detect_active = 1'b0;
        u_if.pwr_detect_refresh = 1'b0;
        cyc(2);
        chk("reset_update", u_if.pwr_detect_update, 0);
        chk("reset_pwr", u_if.pwr_detect_pwr, 0);
        chk("reset_slope", u_if.pwr_detect_slope_up, 0);
        rst_n = 1'b1;
        cyc(1);

        // Constant 100 with n=2: one update every 5 cycles.
        u_if.pwr_detect_active = 1'b1; adc = 8'd100; val = 1'b1;
        wait_upd("const_first_update", 20);
        chk("const_pwr", u_if.pwr_detect_pwr, 100);
        period = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            period++;
            if (u_if.pwr_detect_update) break;
        end
        chk("const_period", period, 5);
        chk("const_prev", u_if.pwr_detect_pwr_prev, 100);
        chk("const_slope", u_if.pwr_detect_slope_up, 0);
        u_if.pwr_detect_active = 1'b0; val = 1'b0;
        cyc(1);
        refresh_pulse();
        chk("refresh_idle_pwr", u_if.pwr_detect_pwr, 0);

        // 10..13 then 20 x4 with a valid gap.
        u_if.pwr_detect_active = 1'b1;
        cyc(1);
        for (int v = 10; v <= 13; v++) feed(v, 1);
        wait_upd("ramp_update", 10);
        chk("ramp_pwr", u_if.pwr_detect_pwr, 11);
        cyc(1);
        feed(20, 2);
        cyc(1);
        feed(20, 2);
        wait_upd("step_update", 10);
        chk("step_pwr", u_if.pwr_detect_pwr, 20);
        chk("step_prev", u_if.pwr_detect_pwr_prev, 11);
        chk("step_slope", u_if.pwr_detect_slope_up, 1);
        u_if.pwr_detect_active = 1'b0;
        cyc(1);
        refresh_pulse();

        // settle=3, n=0: settle-cycle samples ignored, update 5 cycles after active.
        cfg_settle = 8'd3; cfg_n = 4'd0;
        u_if.pwr_detect_active = 1'b1; adc = 8'd200; val = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc(1);
            chk("settle_no_update", u_if.pwr_detect_update, 0);
        end
        adc = 8'd77;
        cyc(1);
        chk("settle_update", u_if.pwr_detect_update, 1);
        chk("settle_pwr", u_if.pwr_detect_pwr, 77);
        chk("settle_slope", u_if.pwr_detect_slope_up, 1);
        u_if.pwr_detect_active = 1'b0; val = 1'b0; cfg_settle = 8'd0; cfg_n = 4'd2;
        cyc(1);

        // Refresh after 2 of 4 samples.
        u_if.pwr_detect_active = 1'b1;
        cyc(1);
        feed(30, 2);
        refresh_pulse();
        chk("refresh_pwr", u_if.pwr_detect_pwr, 0);
        chk("refresh_prev", u_if.pwr_detect_pwr_prev, 0);
        cyc(1);
        feed(50, 4);
        wait_upd("post_refresh_update", 10);
        chk("post_refresh_pwr", u_if.pwr_detect_pwr, 50);
        chk("post_refresh_prev", u_if.pwr_detect_pwr_prev, 0);
        u_if.pwr_detect_active = 1'b0;
        cyc(1);

        // cfg=7 clamps to 16 samples; then drop active mid-window.
        cfg_n = 4'd7;
        u_if.pwr_detect_active = 1'b1;
        cyc(1);
        feed(255, 15);
        chk("clamp_not_yet", u_if.pwr_detect_update, 0);
        feed(255, 1);
        wait_upd("clamp_update", 5);
        chk("clamp_pwr", u_if.pwr_detect_pwr, 255);
        chk("clamp_prev", u_if.pwr_detect_pwr_prev, 50);
        cyc(1);
        feed(0, 8);
        u_if.pwr_detect_active = 1'b0;
        cyc(2);
        chk("drop_no_update", u_if.pwr_detect_update, 0);
        chk("drop_pwr_kept", u_if.pwr_detect_pwr, 255);

        // Reset mid-window.
        cfg_n = 4'd2;
        u_if.pwr_detect_active = 1'b1;
        cyc(1);
        feed(40, 2);
        rst_n = 1'b0;
        cyc(1);
        chk("rst_mid_update", u_if.pwr_detect_update, 0);
        chk("rst_mid_pwr", u_if.pwr_detect_pwr, 0);
        chk("rst_mid_prev", u_if.pwr_detect_pwr_prev, 0);
        chk("rst_mid_slope", u_if.pwr_detect_slope_up, 0);
        rst_n = 1'b1;
        u_if.pwr_detect_active = 1'b0;
        cyc(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
